// File: rtl/vram_writer.sv
// Byte-stream command decoder for the JML-8 mini VGA card: cursor positioning,
// auto-incrementing byte writes and a full-screen fill into 1 bpp video RAM.
module vram_writer #(
    parameter int COLS   = 40,
    parameter int ROWS   = 240,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        datain,
    input  logic              valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              dropped
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
    localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARG_X,
        ARG_Y,
        ARG_W,
        ARG_F,
        FILL
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              dropped_q, dropped_d;
    logic [ADDR_W-1:0] cur_addr;

    function automatic logic [COL_W-1:0] sat_col(input logic [7:0] b);
        if (int'(b) > COLS - 1) return COL_MAX;
        return COL_W'(b);
    endfunction

    function automatic logic [ROW_W-1:0] sat_row(input logic [7:0] b);
        if (int'(b) > ROWS - 1) return ROW_MAX;
        return ROW_W'(b);
    endfunction

    assign cur_addr = ADDR_W'(int'(row_q) * COLS) + ADDR_W'(col_q);

    // During FILL, wr_addr_q doubles as the fill counter and wr_data_q holds the pattern.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        dropped_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    case (datain)
                        8'h01:   state_d = ARG_X;
                        8'h02:   state_d = ARG_Y;
                        8'h03:   state_d = ARG_W;
                        8'h04:   state_d = ARG_F;
                        default: state_d = IDLE;
                    endcase
                end
            end
            ARG_X: begin
                if (valid) begin
                    col_d   = sat_col(datain);
                    state_d = IDLE;
                end
            end
            ARG_Y: begin
                if (valid) begin
                    row_d   = sat_row(datain);
                    state_d = IDLE;
                end
            end
            ARG_W: begin
                if (valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cur_addr;
                    wr_data_d = datain;
                    state_d   = IDLE;
                    if (col_q < COL_MAX) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d = '0;
                        row_d = (row_q == ROW_MAX) ? '0 : row_q + 1'b1;
                    end
                end
            end
            ARG_F: begin
                if (valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = datain;
                    busy_d    = 1'b1;
                    state_d   = FILL;
                end
            end
            FILL: begin
                dropped_d = valid;
                if (wr_addr_q == LAST_ADDR) begin
                    col_d   = '0;
                    row_d   = '0;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    busy_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign dropped = dropped_q;

endmodule

// File: doc/vram_writer.md
# vram_writer

Command decoder between the Z80 bus interface and video RAM on the JML-8 mini VGA card. Consumes the byte stream (`datain` plus one-cycle `valid` strobe) from the bus interface. Interprets it as opcodes with one operand byte each, and drives the video RAM write port. Provides cursor positioning, auto-incrementing byte writes and a hardware full-screen fill. Framebuffer is 1 bpp, 8 horizontal pixels per byte, MSB = leftmost pixel.

## Interface
- `COLS`, default 40: bytes per row (320 px / 8).
- `ROWS`, default 240: rows per frame.
- `ADDR_W`, default 14: video RAM byte-address width; must satisfy 2^ADDR_W >= COLS*ROWS.

- `clk` in 1: card clock; the only clock.
- `reset` in 1: synchronous, active-high reset.
- `datain` in 8: byte from the bus interface.
- `valid` in 1: one-cycle strobe; `datain` is valid in that cycle.
- `wr_en` out 1: video RAM write enable, one cycle per byte written.
- `wr_addr` out ADDR_W: video RAM byte address, = row*COLS + col.
- `wr_data` out 8: byte to write.
- `busy` out 1: fill in progress; incoming bytes are dropped.
- `dropped` out 1: one-cycle pulse when a byte is discarded because `busy` is high.

## Operation
- Cursor registers: `col` (0..COLS-1) and `row` (0..ROWS-1). Address is `row*COLS + col`, a constant multiply, width ADDR_W.
- FSM states: IDLE, ARG_X, ARG_Y, ARG_W, ARG_F, FILL.
- IDLE + valid:
  - 0x01 -> ARG_X.
  - 0x02 -> ARG_Y.
  - 0x03 -> ARG_W.
  - 0x04 -> ARG_F.
  - Any other value is ignored; stay IDLE.
- ARG_X + valid: `col` = min(datain, COLS-1) -> IDLE.
- ARG_Y + valid: `row` = min(datain, ROWS-1) -> IDLE.
- ARG_W + valid: write `datain` at the current cursor, then advance the cursor -> IDLE.
- Cursor advance:
  - If `col` < COLS-1: `col`+1.
  - Otherwise `col`=0 and `row`+1.
  - Row wraps ROWS-1 -> 0, so the last byte wraps to (0,0).
- ARG_F + valid: latch the pattern -> FILL.
- FILL:
  - Writes the pattern to addresses 0..COLS*ROWS-1 in ascending order, one per cycle.
  - After the last address: cursor = (0,0) -> IDLE.
- Argument states have no timeout; they wait indefinitely for the next byte.
- Fill counter is ADDR_W bits wide and is compared against COLS*ROWS-1. It must not overflow.
- `valid` while in FILL: byte discarded, `dropped` pulses in the next cycle, FSM unaffected.
- `valid` in any other state is always accepted; there is no backpressure.

## Timing
- Reset values:
  - State IDLE, `col`=`row`=0.
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0.
  - `busy`=0, `dropped`=0.
- All outputs are registered.
- Write command: operand `valid` in cycle N -> `wr_en`=1 with the pre-advance address and the data in cycle N+1. The cursor is advanced at N+1.
- Back-to-back: a new opcode may arrive at N+1. Consecutive `valid` pulses in adjacent cycles are all handled.
- Fill:
  - Pattern `valid` in cycle N -> `busy`=1 from N+1 through N+COLS*ROWS inclusive.
  - `wr_en`=1 in each of those cycles, address 0 at N+1 up to COLS*ROWS-1 at N+COLS*ROWS.
  - `busy`=0 at N+COLS*ROWS+1, and a new opcode is accepted from that cycle.
- `valid` in the final fill cycle N+COLS*ROWS is dropped.
- `reset` in any cycle, including mid-fill or mid-argument:
  - The next cycle shows all reset values.
  - Fill is aborted and no further writes occur.
- `reset` and `valid` in the same cycle: `valid` is ignored.
- `wr_addr`/`wr_data` hold their last values while `wr_en`=0.

## Test plan
- Reset, then 0x01,0x05,0x02,0x03,0x03,0xA5 -> exactly one write: `wr_en`=1, `wr_addr`=125, `wr_data`=0xA5, one cycle after the 0xA5 strobe.
- Cursor set to (39,239), then two writes 0x11, 0x22 -> addresses 9599 then 0.
- 0x01,0xFF then 0x02,0xFF then a write 0x3C -> saturated to (39,239), write at 9599.
- 0x04,0xFF -> `busy` high exactly 9600 cycles, 9600 writes covering 0..9599 in order, data 0xFF. A `valid` injected mid-fill produces a `dropped` pulse and no other effect. A following write lands at address 0.
- Opcode 0x7E followed by 0x03,0x42 -> 0x7E ignored, single write of 0x42 at address 0.
- `reset` asserted at fill cycle 100 -> `wr_en`=0 and `busy`=0 the next cycle, cursor (0,0). A subsequent write goes to address 0.
